scan_select_seq: RTL and testbench
==================================

# scan_select_seq

Sequential select generator sitting directly upstream of the 2-to-4 decoder. It cycles a 2-bit channel select over the enabled subset of four channels, dwelling a programmable number of clocks on each. It skips masked channels, optionally blanks between channels, and flags frame completion. `sel_a` and `sel_b` drive the decoder's `a` and `b` inputs. `sel_valid` gates the decoded one-hot outputs downstream.

## Interface
- `PRESCALE`, default 1000: clocks per channel dwell; legal range ≥1.
- `BLANK_CYCLES`, default 4: clocks of blanking between channels; legal range ≥1. Used only with `SCAN_SEQ_BLANK_EN`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  scan enable, level.
- `mask`  in  4  channel enable, bit i = channel i.
- `mask_load`  in  1  one-cycle strobe; captures `mask` into the shadow register.
- `sel_a`  out  1  channel index MSB, drives decoder `a`.
- `sel_b`  out  1  channel index LSB, drives decoder `b`.
- `sel_valid`  out  1  select is stable and the channel is live.
- `frame_done`  out  1  one-cycle pulse at the end of each full pass.

## Operation
- Registers:
  - `shadow_mask` (4b), captured on `mask_load`.
  - `active_mask` (4b), the mask in use.
  - `cur` (2b), the current channel.
  - Dwell counter, width `$clog2(PRESCALE+1)`.
  - Blank counter, width `$clog2(BLANK_CYCLES+1)`.
- FSM states: IDLE, DWELL, BLANK.
- Reset values:
  - `sel_a`=0, `sel_b`=0, `sel_valid`=0, `frame_done`=0.
  - `shadow_mask`=0, `active_mask`=0, counters=0, state=IDLE.
- IDLE:
  - Entry condition: `en`=1 and the effective mask is nonzero. The effective mask is `shadow_mask`, or `mask` if `mask_load` is high in the same cycle.
  - On entry: copy the effective mask to `active_mask`. Set `cur` to the lowest enabled index. Go to DWELL. Assert `sel_valid`.
  - Otherwise remain in IDLE with `sel_valid`=0. `cur` holds.
- DWELL:
  - The counter increments each clock. At count `PRESCALE`-1 the dwell ends.
  - At dwell end, copy `shadow_mask` into `active_mask` (mask changes apply only at boundaries).
  - Next channel = first enabled index after `cur` in ascending order, wrapping 3→0. If `cur` is the only enabled channel, next = `cur`.
  - `frame_done` pulses in the boundary cycle when next ≤ `cur`. This includes the single-channel case, where it pulses every dwell.
  - If the new `active_mask` is 0: go to IDLE, `sel_valid`=0, `cur` holds, no `frame_done` pulse.
- BLANK (only with `SCAN_SEQ_BLANK_EN`):
  - `sel_valid`=0 and `cur` holds its old value for `BLANK_CYCLES` clocks.
  - Then `cur` ← next, `sel_valid`=1, and the FSM returns to DWELL.
- `en` low in DWELL or BLANK:
  - Next edge: go to IDLE, `sel_valid`=0, counters cleared, `cur` holds, no `frame_done` pulse.
  - Re-enable restarts from the lowest enabled channel.
- `mask_load` at any time updates `shadow_mask` only. A channel disabled mid-dwell finishes its dwell.
- Invariant: `{sel_a,sel_b}` = `cur`. The select only changes while `sel_valid`=0, or in the cycle `sel_valid` rises. With `SCAN_SEQ_BLANK_EN` undefined, the select changes directly from one dwell to the next.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE→DWELL latency: `en` sampled high at edge N → `sel_valid`=1 and `cur` valid after edge N.
- Each dwell holds `sel_valid`=1 for exactly `PRESCALE` cycles.
- Channel period:
  - `PRESCALE` without blanking.
  - `PRESCALE`+`BLANK_CYCLES` with blanking.
- `frame_done` is asserted in the same cycle as the last dwell cycle of the pass, i.e. the cycle with count `PRESCALE`-1.
- `PRESCALE`=1 without blanking: the channel advances every clock, and `sel_valid` stays high continuously.
- Asynchronous reset mid-scan: all outputs go to their reset values immediately, independent of `clk`.

## Configuration
- Macro: `SCAN_SEQ_BLANK_EN`.
- Defined: the BLANK state is compiled in. `BLANK_CYCLES` idle clocks separate channels, for anti-ghosting on multiplexed displays.
- Undefined: the BLANK state, its counter and the `BLANK_CYCLES` logic are removed. DWELL transitions directly to the next channel.

## Test plan
- Basic scan, `PRESCALE`=4, no blank, `mask`=4'b1111 loaded, `en`=1:
  - `cur` sequence is 0,1,2,3,0, each held 4 clocks; `sel_valid` stays 1.
  - `frame_done` is high only on the 4th clock of channel 3.
- Skip masking, `mask`=4'b1010:
  - `cur` alternates 1,3,1,3.
  - `frame_done` is high on the last cycle of each channel-3 dwell.
  - `mask`=4'b0100: `cur` stays 2, and `frame_done` pulses every 4 clocks.
- Blanking, `SCAN_SEQ_BLANK_EN` defined, `BLANK_CYCLES`=2, `mask`=4'b0011:
  - Sequence: ch0 valid for 4 clocks, `sel_valid`=0 for 2 clocks with `cur`=0, then ch1 valid for 4 clocks.
  - Channel period is 6 clocks.
- Mid-dwell mask change, while on ch1 of 4'b1111 at dwell count 1, load 4'b0001:
  - ch1 finishes its remaining 3 clocks, then the next channel is 0 with a `frame_done` pulse.
  - Loading 4'b0000 instead sends the FSM to IDLE at the boundary, with `sel_valid`=0 and no pulse.
- `en` and reset, on ch2 with count 2:
  - Drop `en`: one edge later `sel_valid`=0 and `cur`=2. Re-raise `en`: the scan restarts at the lowest enabled channel with a full 4-clock dwell.
  - Assert `rst_n`=0 between edges: outputs are immediately 0, and the shadow mask is cleared.

Source files
------------

// File: rtl/scan_select_seq.sv
// Scan select generator: walks a 2-bit channel select over the enabled channels of a 4-bit mask.
// Define SCAN_SEQ_BLANK_EN to insert BLANK_CYCLES of deasserted sel_valid between channels.
module scan_select_seq #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] mask,
    input  logic       mask_load,
    output logic       sel_a,
    output logic       sel_b,
    output logic       sel_valid,
    output logic       frame_done
);

    localparam int DW = $clog2(PRESCALE + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(PRESCALE - 1);

    if (PRESCALE < 1 || BLANK_CYCLES < 1) begin : g_param_check
        $error("scan_select_seq: PRESCALE and BLANK_CYCLES must be >= 1");
    end

`ifdef SCAN_SEQ_BLANK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1, BLANK = 2'd2} state_t;
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    logic [BW-1:0] bcnt, bcnt_n;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1} state_t;
`endif

    state_t        state, state_n;
    logic [3:0]    shadow_mask, active_mask, active_n, eff_mask;
    logic [1:0]    cur, cur_n;
    logic [DW-1:0] cnt, cnt_n;
    logic          sel_valid_n, frame_done_n;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest = 2'(i);
    endfunction

    // First enabled channel after c, wrapping; falls back to c itself when it is the only one.
    function automatic logic [1:0] next_ch(input logic [1:0] c, input logic [3:0] m);
        logic [1:0] idx;
        next_ch = c;
        for (int i = 4; i >= 1; i--) begin
            idx = c + 2'(i);
            if (m[idx]) next_ch = idx;
        end
    endfunction

    // A same-cycle load is visible to the IDLE exit and to the frame_done lookahead.
    assign eff_mask = mask_load ? mask : shadow_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow_mask <= 4'd0;
            active_mask <= 4'd0;
            cur         <= 2'd0;
            cnt         <= '0;
            sel_valid   <= 1'b0;
            frame_done  <= 1'b0;
`ifdef SCAN_SEQ_BLANK_EN
            bcnt        <= '0;
`endif
        end else begin
            state       <= state_n;
            shadow_mask <= eff_mask;
            active_mask <= active_n;
            cur         <= cur_n;
            cnt         <= cnt_n;
            sel_valid   <= sel_valid_n;
            frame_done  <= frame_done_n;
`ifdef SCAN_SEQ_BLANK_EN
            bcnt        <= bcnt_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        active_n = active_mask;
        cur_n    = cur;
        cnt_n    = cnt;
`ifdef SCAN_SEQ_BLANK_EN
        bcnt_n   = bcnt;
`endif
        case (state)
            IDLE: begin
                if (en && eff_mask != 4'd0) begin
                    state_n  = DWELL;
                    active_n = eff_mask;
                    cur_n    = lowest(eff_mask);
                    cnt_n    = '0;
                end
            end
            DWELL: begin
                if (!en) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DWELL_LAST) begin
                    cnt_n    = '0;
                    active_n = shadow_mask;
                    if (shadow_mask == 4'd0) begin
                        state_n = IDLE;
                    end else begin
`ifdef SCAN_SEQ_BLANK_EN
                        state_n = BLANK;
                        bcnt_n  = '0;
`else
                        cur_n   = next_ch(cur, shadow_mask);
`endif
                    end
                end else begin
                    cnt_n = cnt + DW'(1);
                end
            end
`ifdef SCAN_SEQ_BLANK_EN
            BLANK: begin
                if (!en) begin
                    state_n = IDLE;
                    bcnt_n  = '0;
                end else if (bcnt == BLANK_LAST) begin
                    state_n = DWELL;
                    bcnt_n  = '0;
                    cur_n   = next_ch(cur, active_mask);
                end else begin
                    bcnt_n = bcnt + BW'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered, so frame_done is predicted one edge early: the mask that the
    // coming boundary will adopt is exactly the shadow value being written at this edge.
    always_comb begin
        sel_valid_n  = (state_n == DWELL);
        frame_done_n = (state_n == DWELL) && (cnt_n == DWELL_LAST) &&
                       (eff_mask != 4'd0) && (next_ch(cur_n, eff_mask) <= cur_n);
    end

    assign sel_a = cur[1];
    assign sel_b = cur[0];

endmodule

// File: tb/tb_scan_select_seq.sv
// Vector-table bench for scan_select_seq (PRESCALE=4, BLANK_CYCLES=2) with a scoreboard queue.
module tb_scan_select_seq;

    localparam int PRESCALE     = 4;
    localparam int BLANK_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] mask = 4'd0;
    logic       mask_load = 1'b0;
    logic       sel_a, sel_b, sel_valid, frame_done;

    always #5 clk = ~clk;

    scan_select_seq #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mask(mask), .mask_load(mask_load),
        .sel_a(sel_a), .sel_b(sel_b), .sel_valid(sel_valid), .frame_done(frame_done)
    );

    typedef struct {
        logic       en;
        logic       ld;
        logic [3:0] mask;
        logic       v;
        logic [1:0] cur;
        logic       fd;
        string      tag;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        string      tag;
        int         idx;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic e, input logic ld, input logic [3:0] m,
                                input logic v, input logic [1:0] c, input logic fd,
                                input string tag);
        vec_t t;
        t.en = e; t.ld = ld; t.mask = m; t.v = v; t.cur = c; t.fd = fd; t.tag = tag;
        tbl.push_back(t);
    endfunction

    task automatic check(input logic [3:0] got, input logic [3:0] exp, input string tag, input int idx);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got {valid,a,b,frame_done}=%b, want %b", tag, idx, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the expected state after the next rising edge
    // is queued and checked 1 time unit after that edge.
    task automatic run_table();
        sb_t s;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            en        = tbl[i].en;
            mask_load = tbl[i].ld;
            mask      = tbl[i].mask;
            s.exp = {tbl[i].v, tbl[i].cur, tbl[i].fd};
            s.tag = tbl[i].tag;
            s.idx = i;
            sb.push_back(s);
            @(posedge clk);
            #1;
            s = sb.pop_front();
            check({sel_valid, sel_a, sel_b, frame_done}, s.exp, s.tag, s.idx);
        end
        tbl.delete();
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0; en = 1'b0; mask_load = 1'b0; mask = 4'd0;
        #1;
        check({sel_valid, sel_a, sel_b, frame_done}, 4'b0000, tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset("reset_init");

        // Full mask, load first with en low, then scan 0,1,2,3,0.
        add(1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, "load_idle");
        for (int k = 0; k < 20; k++)
            add(1'b1, 1'b0, 4'b0000, 1'b1, 2'((k / 4) % 4),
                (k % 4 == 3) && ((k / 4) % 4 == 3), "basic");
        run_table();

        // Load and enable in the same cycle; 1010 alternates 1,3, then switch to single channel 2.
        do_reset("reset_skip");
        for (int k = 0; k < 16; k++)
            add(1'b1, k == 0, (k == 0) ? 4'b1010 : 4'b0000, 1'b1,
                ((k / 4) % 2 == 1) ? 2'd3 : 2'd1,
                (k % 4 == 3) && ((k / 4) % 2 == 1), "skip");
        for (int k = 16; k < 32; k++)
            add(1'b1, k == 16, (k == 16) ? 4'b0100 : 4'b0000, 1'b1,
                (k < 20) ? 2'd1 : 2'd2, (k >= 20) && (k % 4 == 3), "single");
        run_table();

        // Mid-dwell load of 0001 on ch1 count 1, later 0000 sends the scan to idle.
        do_reset("reset_mid");
        for (int k = 0; k < 18; k++)
            add(1'b1, (k == 0) || (k == 6) || (k == 12),
                (k == 0) ? 4'b1111 : 4'b0001 & {4{k == 6}},
                k <= 15, (k >= 4 && k <= 7) ? 2'd1 : 2'd0,
                (k == 7) || (k == 11), "mask_chg");
        run_table();

        // Drop en on ch2 count 2, then re-enable: restart at ch0 with a full dwell.
        do_reset("reset_en");
        for (int k = 0; k < 23; k++)
            add(!(k == 11 || k == 12), k == 0, (k == 0) ? 4'b1111 : 4'b0000,
                !(k == 11 || k == 12),
                (k <= 3)  ? 2'd0 : (k <= 7)  ? 2'd1 : (k <= 12) ? 2'd2 :
                (k <= 16) ? 2'd0 : (k <= 20) ? 2'd1 : 2'd2,
                1'b0, "en_drop");
        run_table();

        // Async reset mid-dwell clears outputs and the shadow mask.
        do_reset("reset_async");
        for (int k = 0; k < 4; k++)
            add(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, "shadow_clr");
        run_table();

`ifdef SCAN_SEQ_BLANK_EN
        // Two blank cycles between channels: period 6, cur held through blanking.
        do_reset("reset_blank");
        for (int k = 0; k < 18; k++)
            add(1'b1, k == 0, (k == 0) ? 4'b0011 : 4'b0000, (k % 6) < 4,
                2'((k / 6) % 2), (k % 6 == 3) && ((k / 6) % 2 == 1), "blank");
        run_table();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
